sync_fifo_ctrl: RTL and testbench
=================================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, storage words; power of two, min 4.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-4, almost_full threshold in words.
REQ-004 SHALL have parameter AEMPTY_TH, default 4, almost_empty threshold in words.
REQ-005 SHALL have sys_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have sys_rst_n  input  1  reset; synchronous, active-low.
REQ-007 SHALL have wr_en  input  1  write request.
REQ-008 SHALL have din  input  DATA_W  write data.
REQ-009 SHALL have rd_en  input  1  read request.
REQ-010 SHALL have clr_err  input  1  clears the sticky error flags.
REQ-011 SHALL have dout  output  DATA_W  read data.
REQ-012 SHALL have full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 SHALL have data_count  output  log2(DEPTH)+1  words held.
REQ-014 SHALL have overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Storage SHALL be a DEPTH x DATA_W array addressed by log2(DEPTH)-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-016 A write SHALL occur when wr_en=1 and (full=0 or a read occurs on the same edge); din goes to the write pointer and the pointer increments.
REQ-017 A read SHALL occur when rd_en=1 and empty=0; the read pointer increments.
REQ-018 Standard mode: dout SHALL present the popped word after the edge on which the read occurs (1-cycle latency), and hold its value otherwise.
REQ-019 data_count SHALL be +1 on a write-only edge, -1 on a read-only edge, and unchanged on a simultaneous read and write.
REQ-020 Flags SHALL be registered and reflect the count after the current edge.
- full = (count==DEPTH); empty = (count==0).
- almost_full = (count>=AFULL_TH); almost_empty = (count<=AEMPTY_TH).
REQ-021 wr_en=1 while full=1 with no read SHALL drop the word, leave the state unchanged, and set overflow.
REQ-022 rd_en=1 while empty=1 SHALL be ignored, set underflow, and leave dout unchanged; a write on the same edge still occurs.
REQ-023 overflow and underflow SHALL stay set until clr_err=1 is sampled; clr_err clears both on that edge. If clr_err and a new error occur on the same edge, the flag SHALL end set.
REQ-024 Write to empty FIFO on edge N (standard mode): empty SHALL be 0 after edge N, and the word is readable from the cycle after edge N.

Reset
REQ-025 When sys_rst_n=0 on an edge, the block SHALL set: pointers=0, data_count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
REQ-026 Reset SHALL take priority over wr_en, rd_en and clr_err on the same edge; a reset mid-stream discards all content. Array contents need not be cleared.
REQ-027 The first write SHALL be accepted on the first edge with sys_rst_n=1.

Configuration
REQ-028 Macro SYNC_FIFO_FWFT_EN, when defined, SHALL select first-word fall-through mode.
- dout shows the head word whenever empty=0.
- rd_en pops it, and the next word (if any) appears after that same edge.
REQ-029 In FWFT mode the head word SHALL sit in an output register counted in data_count.
- Write to empty FIFO on edge N: dout=word and empty=0 after edge N+1.
- full still asserts at data_count==DEPTH.
REQ-030 When the macro is undefined, standard mode (REQ-018, REQ-024) SHALL apply and no output-register prefetch logic SHALL be built.

Verification (DEPTH=16, DATA_W=8, AFULL_TH=12, AEMPTY_TH=4)
REQ-031 Reset with wr_en=1 and rd_en=1 held -> after the edge: empty=1, almost_empty=1, full=0, data_count=0, dout=0, overflow=0, underflow=0.
REQ-032 Write 0x00..0x0F, then read 16 -> full=1 after the 16th write, almost_full=1 from the 12th; reads return 0x00..0x0F in order; empty=1 after the last read.
REQ-033 While full, write 0xAA without read -> overflow=1, data_count=16, and 0xAA is never read back; pulse clr_err -> overflow=0.
REQ-034 With count=16, write and read simultaneously for 40 cycles (pointer wrap) -> data_count stays 16, full stays 1, no overflow, data order is preserved.
REQ-035 rd_en on empty with a simultaneous write of 0x55 -> underflow=1, data_count=1; next read returns 0x55 (standard mode: 1 cycle after rd_en; FWFT: dout=0x55 before rd_en).
REQ-036 Reset asserted at count=7 -> data_count=0 and empty=1 after the edge; the following write and read return the new word, not any old one.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl -- single-clock FIFO controller with registered status flags.
//
// Parameters
//   DATA_W     data word width
//   DEPTH      storage words (power of two, >= 4)
//   AFULL_TH   almost_full asserts when data_count >= AFULL_TH
//   AEMPTY_TH  almost_empty asserts when data_count <= AEMPTY_TH
//
// Ports
//   sys_clk       clock, rising edge
//   sys_rst_n     synchronous active-low reset
//   wr_en, din    write request and data
//   rd_en         read request
//   clr_err       clears overflow/underflow
//   dout          read data
//   full, empty, almost_full, almost_empty   registered status flags
//   data_count    words held
//   overflow, underflow                      sticky error flags
//
// Build option
//   SYNC_FIFO_FWFT_EN  first-word fall-through: the head word is prefetched
//                      into the dout register, which is part of data_count.
//                      Undefined (default) gives a standard 1-cycle-latency read.

module sync_fifo_ctrl #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 256,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = 4
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          din,
   input  logic                       rd_en,
   input  logic                       clr_err,
   output logic [DATA_W-1:0]          dout,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     data_count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count_nxt;
   logic              rd_ok;
   logic              wr_ok;
   logic              mem_rd;
   logic              empty_nxt;
   logic              ovf_evt;
   logic              udf_evt;

`ifdef SYNC_FIFO_FWFT_EN
   // mem_cnt tracks the array only; data_count also includes the dout register.
   logic          out_valid;
   logic          out_valid_nxt;
   logic [CW-1:0] mem_cnt;
   logic [CW-1:0] mem_cnt_nxt;

   assign rd_ok         = rd_en && out_valid;
   // Refill the output register whenever it is (or is about to become) free.
   assign mem_rd        = (mem_cnt != '0) && (!out_valid || rd_ok);
   assign out_valid_nxt = mem_rd || (out_valid && !rd_ok);
   assign empty_nxt     = !out_valid_nxt;
   assign udf_evt       = rd_en && !out_valid;

   always_comb begin
      mem_cnt_nxt = mem_cnt;
      case ({wr_ok, mem_rd})
         2'b10:   mem_cnt_nxt = mem_cnt + CW'(1);
         2'b01:   mem_cnt_nxt = mem_cnt - CW'(1);
         default: mem_cnt_nxt = mem_cnt;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         out_valid <= 1'b0;
         mem_cnt   <= '0;
      end else begin
         out_valid <= out_valid_nxt;
         mem_cnt   <= mem_cnt_nxt;
      end
   end
`else
   assign rd_ok     = rd_en && !empty;
   assign mem_rd    = rd_ok;
   assign empty_nxt = (count_nxt == '0);
   assign udf_evt   = rd_en && empty;
`endif

   // A read on the same edge frees a slot, so a full FIFO still accepts a write.
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign ovf_evt = wr_en && !wr_ok;

   always_comb begin
      count_nxt = data_count;
      case ({wr_ok, rd_ok})
         2'b10:   count_nxt = data_count + CW'(1);
         2'b01:   count_nxt = data_count - CW'(1);
         default: count_nxt = data_count;
      endcase
   end

   // Array has no reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge sys_clk) begin
      if (sys_rst_n && wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         data_count   <= '0;
         dout         <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (mem_rd) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         data_count   <= count_nxt;
         full         <= (count_nxt == CW'(DEPTH));
         empty        <= empty_nxt;
         almost_full  <= (count_nxt >= CW'(AFULL_TH));
         almost_empty <= (count_nxt <= CW'(AEMPTY_TH));
         // A new error on the clearing edge wins over clr_err.
         overflow     <= (overflow  && !clr_err) || ovf_evt;
         underflow    <= (underflow && !clr_err) || udf_evt;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AFT   = 12;
   localparam int AET   = 4;

   logic          sys_clk   = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          wr_en     = 1'b0;
   logic          rd_en     = 1'b0;
   logic          clr_err   = 1'b0;
   logic [DW-1:0] din       = '0;
   logic [DW-1:0] dout;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0]    data_count;

   sync_fifo_ctrl #(
      .DATA_W    (DW),
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFT),
      .AEMPTY_TH (AET)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .clr_err      (clr_err),
      .dout         (dout),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .data_count   (data_count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: a queue of words, last popped word, sticky errors.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   bit            m_ovf;
   bit            m_udf;

   int n_checks = 0;
   int n_errors = 0;

   function automatic logic [5:0] exp_flags();
      int n;
      n = q.size();
      return {n == DEPTH, n == 0, n >= AFT, n <= AET, m_ovf, m_udf};
   endfunction

   function automatic logic [5:0] act_flags();
      return {full, empty, almost_full, almost_empty, overflow, underflow};
   endfunction

   // Apply one cycle of stimulus to DUT and model; returns #1 after the edge.
   task automatic drive(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit c, input bit rst_n);
      bit rd_ok, wr_ok, new_ovf, new_udf;
      @(negedge sys_clk);
      wr_en = w; din = d; rd_en = r; clr_err = c; sys_rst_n = rst_n;
      if (!rst_n) begin
         q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         rd_ok   = r && (q.size() > 0);
         wr_ok   = w && (q.size() < DEPTH || rd_ok);
         new_ovf = w && !wr_ok;
         new_udf = r && (q.size() == 0);
         if (rd_ok) m_dout = q.pop_front();
         if (wr_ok) q.push_back(d);
         m_ovf = (m_ovf && !c) || new_ovf;
         m_udf = (m_udf && !c) || new_udf;
      end
      @(posedge sys_clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; sys_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (act_flags() !== 6'b010100) begin
         n_errors++;
         $display("FAIL reset_flags: got %b expected %b", act_flags(), 6'b010100);
      end
      n_checks++;
      if (data_count !== 5'd0) begin
         n_errors++;
         $display("FAIL reset_count: got %0d expected 0", data_count);
      end
      n_checks++;
      if (dout !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_dout: got %h expected 00", dout);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
         n_checks++;
         if (data_count !== 5'(i + 1) || act_flags() !== exp_flags()) begin
            n_errors++;
            $display("FAIL fill_%0d: count %0d flags %b expected count %0d flags %b",
                     i, data_count, act_flags(), i + 1, exp_flags());
         end
      end
      n_checks++;
      if (full !== 1'b1 || almost_full !== 1'b1) begin
         n_errors++;
         $display("FAIL fill_full: full %b almost_full %b expected 1 1", full, almost_full);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
         n_checks++;
         if (dout !== 8'(i) || act_flags() !== exp_flags()) begin
            n_errors++;
            $display("FAIL drain_%0d: dout %h flags %b expected dout %h flags %b",
                     i, dout, act_flags(), 8'(i), exp_flags());
         end
      end
      n_checks++;
      if (empty !== 1'b1 || data_count !== 5'd0) begin
         n_errors++;
         $display("FAIL drain_empty: empty %b count %0d expected 1 0", empty, data_count);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom_range(0, 8'h9F)), 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (overflow !== 1'b1 || data_count !== 5'd16 || full !== 1'b1) begin
         n_errors++;
         $display("FAIL overflow_set: ovf %b count %0d full %b expected 1 16 1",
                  overflow, data_count, full);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL overflow_clr: ovf %b expected 0", overflow);
      end
      drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (overflow !== 1'b1 || data_count !== 5'd16) begin
         n_errors++;
         $display("FAIL overflow_clr_collide: ovf %b count %0d expected 1 16", overflow, data_count);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'($urandom_range(0, 8'h9F)), 1'b1, 1'b0, 1'b1);
         n_checks++;
         if (data_count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || dout !== m_dout) begin
            n_errors++;
            $display("FAIL wrap_%0d: count %0d full %b ovf %b dout %h expected 16 1 0 %h",
                     i, data_count, full, overflow, dout, m_dout);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
         n_checks++;
         if (dout !== m_dout || dout === 8'hAA) begin
            n_errors++;
            $display("FAIL wrap_drain_%0d: dout %h expected %h", i, dout, m_dout);
         end
      end
   endtask

   task automatic test_underflow();
      logic [DW-1:0] prev;
      prev = m_dout;
      drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (underflow !== 1'b1 || data_count !== 5'd1 || dout !== prev) begin
         n_errors++;
         $display("FAIL underflow_set: udf %b count %0d dout %h expected 1 1 %h",
                  underflow, data_count, dout, prev);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (dout !== 8'h55 || empty !== 1'b1) begin
         n_errors++;
         $display("FAIL underflow_read: dout %h empty %b expected 55 1", dout, empty);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (underflow !== 1'b1 || dout !== 8'h55) begin
         n_errors++;
         $display("FAIL underflow_clr_collide: udf %b dout %h expected 1 55", underflow, dout);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (underflow !== 1'b0) begin
         n_errors++;
         $display("FAIL underflow_clr: udf %b expected 0", underflow);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (data_count !== 5'd0 || empty !== 1'b1 || dout !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_mid: count %0d empty %b dout %h expected 0 1 00",
                  data_count, empty, dout);
      end
      drive(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (dout !== 8'hC3 || empty !== 1'b1 || underflow !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_read: dout %h empty %b udf %b expected C3 1 0",
                  dout, empty, underflow);
      end
   endtask

   task automatic test_random();
      bit w, r, c;
      for (int i = 0; i < 400; i++) begin
         // Bias alternates between filling and draining phases.
         w = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 30));
         r = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
         c = ($urandom_range(0, 15) == 0);
         drive(w, 8'($urandom_range(0, 255)), r, c, 1'b1);
         n_checks++;
         if (data_count !== 5'(q.size()) || act_flags() !== exp_flags() || dout !== m_dout) begin
            n_errors++;
            $display("FAIL random_%0d: count %0d flags %b dout %h expected %0d %b %h",
                     i, data_count, act_flags(), dout, q.size(), exp_flags(), m_dout);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_wrap();
      test_underflow();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
